rvfi_commit_queue: RTL and testbench

Transmit side of the RVFI commit interface. Collects per-instruction trace fields from the core's dispatch and writeback points, reorders them into program order, and drives one registered RVFI commit packet per cycle with a monotonically increasing order number. It sits between the core pipeline and the RVFI monitor port, so out-of-order completion is invisible to the checker.

---
 rtl/rvfi_pkg.sv | 50 +++++
 rtl/rvfi_commit_queue.sv | 197 +++++++++++++++++++
 tb/tb_rvfi_commit_queue.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvfi_pkg.sv
// Shared types for the RVFI commit queue: the writeback payload, the queue entry,
// the emit-time normalisation rule and the halt-instruction encodings.
package rvfi_pkg;

    // Self-loop encodings the core uses to park itself at the end of a program.
    localparam logic [31:0] HALT_INST_BEQ  = 32'h0000_0063;
    localparam logic [31:0] HALT_INST_JAL  = 32'h0000_006f;
    localparam logic [31:0] HALT_INST_SLTI = 32'hF000_2013;

    typedef struct packed {
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_wb_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        rvfi_wb_t    wb;
        logic        valid;
        logic        done;
    } rvfi_entry_t;

    // x0 reads as zero and writes to x0 are discarded, so the trace must show zeros.
    function automatic rvfi_wb_t rvfi_normalize(input rvfi_wb_t w);
        rvfi_wb_t n;
        n = w;
        if (w.rs1_addr == 5'd0) n.rs1_rdata = 32'd0;
        if (w.rs2_addr == 5'd0) n.rs2_rdata = 32'd0;
        if (w.rd_addr == 5'd0)  n.rd_wdata  = 32'd0;
        return n;
    endfunction

    function automatic logic rvfi_is_halt(input logic [31:0] pc,
                                          input logic [31:0] inst,
                                          input logic [31:0] pc_wdata);
        return (pc == pc_wdata) || (inst == HALT_INST_BEQ) ||
               (inst == HALT_INST_JAL) || (inst == HALT_INST_SLTI);
    endfunction

endpackage

// File: rtl/rvfi_commit_queue.sv
// Reorders out-of-order completions into program order and emits one registered RVFI packet per cycle.
// Optional halt detection is built when RVFI_HALT_DETECT_EN is defined.
module rvfi_commit_queue
    import rvfi_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispatch_valid,
    output logic              dispatch_ready,
    input  logic [31:0]       dispatch_pc,
    input  logic [31:0]       dispatch_inst,
    output logic [TAG_W-1:0]  dispatch_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  rvfi_wb_t          wb_pkt,
    input  logic              flush_valid,
    input  logic [TAG_W-1:0]  flush_tag,
    output logic              rvfi_valid,
    output logic [63:0]       rvfi_order,
    output logic [31:0]       rvfi_inst,
    output logic [31:0]       rvfi_pc_rdata,
    output logic [31:0]       rvfi_pc_wdata,
    output logic [4:0]        rvfi_rs1_addr,
    output logic [4:0]        rvfi_rs2_addr,
    output logic [4:0]        rvfi_rd_addr,
    output logic [31:0]       rvfi_rs1_rdata,
    output logic [31:0]       rvfi_rs2_rdata,
    output logic [31:0]       rvfi_rd_wdata,
    output logic [31:0]       rvfi_mem_addr,
    output logic [31:0]       rvfi_mem_rdata,
    output logic [31:0]       rvfi_mem_wdata,
    output logic [3:0]        rvfi_mem_rmask,
    output logic [3:0]        rvfi_mem_wmask,
    output logic              rvfi_halt
);

    typedef logic [TAG_W:0] ptr_t;

    rvfi_entry_t entry_q [DEPTH];
    rvfi_entry_t entry_w [DEPTH];
    rvfi_entry_t entry_d [DEPTH];

    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    logic [63:0] order_cnt_q, order_cnt_d;

    logic        out_valid_q, out_valid_d;
    logic [63:0] out_order_q, out_order_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    rvfi_wb_t    out_wb_q, out_wb_d;

    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic [TAG_W-1:0] flush_off;
    ptr_t             surv;
    logic             full;
    logic             dispatch_fire;
    logic             emit;
    logic             halt_block;
    rvfi_entry_t      head_e;

    assign head_idx       = head_q[TAG_W-1:0];
    assign tail_idx       = tail_q[TAG_W-1:0];
    assign full           = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign dispatch_ready = !full;
    assign dispatch_tag   = tail_idx;
    assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush_valid;

    // Entries from head up to and including flush_tag survive a flush.
    assign flush_off = flush_tag - head_idx;
    assign surv      = {1'b0, flush_off} + ptr_t'(1);

    // Dispatch and writeback merged first, so a writeback landing this cycle can commit at the edge.
    always_comb begin
        entry_w = entry_q;
        if (dispatch_fire) begin
            entry_w[tail_idx].pc    = dispatch_pc;
            entry_w[tail_idx].inst  = dispatch_inst;
            entry_w[tail_idx].valid = 1'b1;
            entry_w[tail_idx].done  = 1'b0;
        end
        if (wb_valid && entry_w[wb_tag].valid) begin
            entry_w[wb_tag].done = 1'b1;
            entry_w[wb_tag].wb   = wb_pkt;
        end
    end

    assign head_e = entry_w[head_idx];
    assign emit   = head_e.valid && head_e.done && !halt_block;

    always_comb begin
        logic [TAG_W-1:0] slot_off;
        slot_off    = '0;
        entry_d     = entry_w;
        head_d      = head_q;
        tail_d      = tail_q;
        order_cnt_d = order_cnt_q;
        if (dispatch_fire) tail_d = tail_q + ptr_t'(1);
        if (emit) begin
            entry_d[head_idx].valid = 1'b0;
            entry_d[head_idx].done  = 1'b0;
            head_d      = head_q + ptr_t'(1);
            order_cnt_d = order_cnt_q + 64'd1;
        end
        if (flush_valid) begin
            tail_d = head_q + surv;
            for (int i = 0; i < DEPTH; i++) begin
                slot_off = TAG_W'(i) - head_idx;
                if ({1'b0, slot_off} >= surv) begin
                    entry_d[i].valid = 1'b0;
                    entry_d[i].done  = 1'b0;
                end
            end
        end
    end

    // Data outputs hold their last packet when nothing commits.
    always_comb begin
        out_valid_d = 1'b0;
        out_order_d = out_order_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_wb_d    = out_wb_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_order_d = order_cnt_q;
            out_pc_d    = head_e.pc;
            out_inst_d  = head_e.inst;
            out_wb_d    = rvfi_normalize(head_e.wb);
        end
    end

`ifdef RVFI_HALT_DETECT_EN
    logic halt_q, halt_d;

    always_comb begin
        halt_d = halt_q || (emit && rvfi_is_halt(head_e.pc, head_e.inst, head_e.wb.pc_wdata));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) halt_q <= 1'b0;
        else     halt_q <= halt_d;
    end

    assign halt_block = halt_q;
    assign rvfi_halt  = halt_q;
`else
    assign halt_block = 1'b0;
    assign rvfi_halt  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            order_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_order_q <= '0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            out_wb_q    <= '0;
        end else begin
            entry_q     <= entry_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            order_cnt_q <= order_cnt_d;
            out_valid_q <= out_valid_d;
            out_order_q <= out_order_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_wb_q    <= out_wb_d;
        end
    end

    assign rvfi_valid     = out_valid_q;
    assign rvfi_order     = out_order_q;
    assign rvfi_inst      = out_inst_q;
    assign rvfi_pc_rdata  = out_pc_q;
    assign rvfi_pc_wdata  = out_wb_q.pc_wdata;
    assign rvfi_rs1_addr  = out_wb_q.rs1_addr;
    assign rvfi_rs2_addr  = out_wb_q.rs2_addr;
    assign rvfi_rd_addr   = out_wb_q.rd_addr;
    assign rvfi_rs1_rdata = out_wb_q.rs1_rdata;
    assign rvfi_rs2_rdata = out_wb_q.rs2_rdata;
    assign rvfi_rd_wdata  = out_wb_q.rd_wdata;
    assign rvfi_mem_addr  = out_wb_q.mem_addr;
    assign rvfi_mem_rdata = out_wb_q.mem_rdata;
    assign rvfi_mem_wdata = out_wb_q.mem_wdata;
    assign rvfi_mem_rmask = out_wb_q.mem_rmask;
    assign rvfi_mem_wmask = out_wb_q.mem_wmask;

endmodule

// File: tb/tb_rvfi_commit_queue.sv
// Bench for rvfi_commit_queue: directed scenarios plus random traffic against a program-order queue model.
`timescale 1ns/1ps
module tb_rvfi_commit_queue;
    import rvfi_pkg::*;

    localparam int DEPTH = 8;
    localparam int TAG_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             dispatch_valid = 1'b0;
    logic             dispatch_ready;
    logic [31:0]      dispatch_pc = '0;
    logic [31:0]      dispatch_inst = '0;
    logic [TAG_W-1:0] dispatch_tag;
    logic             wb_valid = 1'b0;
    logic [TAG_W-1:0] wb_tag = '0;
    rvfi_wb_t         wb_pkt = '0;
    logic             flush_valid = 1'b0;
    logic [TAG_W-1:0] flush_tag = '0;
    logic             rvfi_valid;
    logic [63:0]      rvfi_order;
    logic [31:0]      rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata;
    logic [4:0]       rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0]      rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0]      rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [3:0]       rvfi_mem_rmask, rvfi_mem_wmask;
    logic             rvfi_halt;

    always #5 clk = ~clk;

    rvfi_commit_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_pc(dispatch_pc), .dispatch_inst(dispatch_inst), .dispatch_tag(dispatch_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_pkt(wb_pkt),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_inst(rvfi_inst), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_halt(rvfi_halt)
    );

    // Reference model: in-flight instructions oldest first; element k carries tag (m_head+k)%DEPTH.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        rvfi_wb_t    wb;
        logic        done;
    } mrec_t;

    mrec_t       mq[$];
    int          m_head;
    logic [63:0] m_order;
    logic        exp_valid;
    logic [63:0] exp_order;
    logic [31:0] exp_pc, exp_inst;
    rvfi_wb_t    exp_wb;
    logic        exp_halt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_head    = 0;
        m_order   = '0;
        exp_valid = 1'b0;
        exp_order = '0;
        exp_pc    = '0;
        exp_inst  = '0;
        exp_wb    = '0;
        exp_halt  = 1'b0;
    endtask

    task automatic model_step(input logic dv, input logic [31:0] pc, input logic [31:0] inst,
                              input logic wv, input logic [TAG_W-1:0] wt, input rvfi_wb_t pkt,
                              input logic fv, input logic [TAG_W-1:0] ft);
        mrec_t r;
        int    keep;
        int    k;
        bit    room;
        room = mq.size() < DEPTH;
        keep = ((int'(ft) - m_head + DEPTH) % DEPTH) + 1;
        if (dv && room && !fv) begin
            r = '0;
            r.pc = pc;
            r.inst = inst;
            mq.push_back(r);
        end
        if (wv) begin
            k = (int'(wt) - m_head + DEPTH) % DEPTH;
            if (k < mq.size()) begin
                r = mq[k];
                r.done = 1'b1;
                r.wb = pkt;
                mq[k] = r;
            end
        end
        exp_valid = 1'b0;
        if (!exp_halt && mq.size() > 0 && mq[0].done) begin
            r = mq.pop_front();
            exp_valid = 1'b1;
            exp_order = m_order;
            m_order   = m_order + 1;
            m_head    = (m_head + 1) % DEPTH;
            keep      = keep - 1;
            exp_pc    = r.pc;
            exp_inst  = r.inst;
            exp_wb    = r.wb;
            if (r.wb.rs1_addr == 0) exp_wb.rs1_rdata = 0;
            if (r.wb.rs2_addr == 0) exp_wb.rs2_rdata = 0;
            if (r.wb.rd_addr == 0)  exp_wb.rd_wdata  = 0;
`ifdef RVFI_HALT_DETECT_EN
            if (r.pc == r.wb.pc_wdata ||
                (r.inst inside {32'h0000_0063, 32'h0000_006f, 32'hF000_2013}))
                exp_halt = 1'b1;
`endif
        end
        if (fv) begin
            while (mq.size() > keep) void'(mq.pop_back());
        end
    endtask

    task automatic check_outputs();
        chk("valid", rvfi_valid, exp_valid);
        chk("order", rvfi_order, exp_order);
        chk("inst", rvfi_inst, exp_inst);
        chk("pc_rdata", rvfi_pc_rdata, exp_pc);
        chk("pc_wdata", rvfi_pc_wdata, exp_wb.pc_wdata);
        chk("rs1_addr", rvfi_rs1_addr, exp_wb.rs1_addr);
        chk("rs2_addr", rvfi_rs2_addr, exp_wb.rs2_addr);
        chk("rd_addr", rvfi_rd_addr, exp_wb.rd_addr);
        chk("rs1_rdata", rvfi_rs1_rdata, exp_wb.rs1_rdata);
        chk("rs2_rdata", rvfi_rs2_rdata, exp_wb.rs2_rdata);
        chk("rd_wdata", rvfi_rd_wdata, exp_wb.rd_wdata);
        chk("mem_addr", rvfi_mem_addr, exp_wb.mem_addr);
        chk("mem_rdata", rvfi_mem_rdata, exp_wb.mem_rdata);
        chk("mem_wdata", rvfi_mem_wdata, exp_wb.mem_wdata);
        chk("mem_rmask", rvfi_mem_rmask, exp_wb.mem_rmask);
        chk("mem_wmask", rvfi_mem_wmask, exp_wb.mem_wmask);
        chk("halt", rvfi_halt, exp_halt);
        chk("dispatch_ready", dispatch_ready, mq.size() < DEPTH);
        chk("dispatch_tag", dispatch_tag, (m_head + mq.size()) % DEPTH);
    endtask

    task automatic drive_idle();
        dispatch_valid = 1'b0;
        wb_valid       = 1'b0;
        flush_valid    = 1'b0;
    endtask

    // One clock: check what the last edge produced, then present new inputs for the next edge.
    task automatic step(input logic dv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic wv, input logic [TAG_W-1:0] wt, input rvfi_wb_t pkt,
                        input logic fv, input logic [TAG_W-1:0] ft);
        @(negedge clk);
        check_outputs();
        dispatch_valid = dv;
        dispatch_pc    = pc;
        dispatch_inst  = inst;
        wb_valid       = wv;
        wb_tag         = wt;
        wb_pkt         = pkt;
        flush_valid    = fv;
        flush_tag      = ft;
        model_step(dv, pc, inst, wv, wt, pkt, fv, ft);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic disp(input logic [31:0] pc, input logic [31:0] inst);
        step(1'b1, pc, inst, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic wb(input logic [TAG_W-1:0] t, input rvfi_wb_t p);
        step(1'b0, '0, '0, 1'b1, t, p, 1'b0, '0);
    endtask

    task automatic reset_dut();
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic async_reset_check();
        #2;
        rst = 1'b1;
        drive_idle();
        #1;
        chk("rst_valid", rvfi_valid, 1'b0);
        chk("rst_order", rvfi_order, 64'd0);
        chk("rst_pc_rdata", rvfi_pc_rdata, 32'd0);
        chk("rst_inst", rvfi_inst, 32'd0);
        chk("rst_rd_wdata", rvfi_rd_wdata, 32'd0);
        chk("rst_mem_addr", rvfi_mem_addr, 32'd0);
        chk("rst_halt", rvfi_halt, 1'b0);
        chk("rst_ready", dispatch_ready, 1'b1);
        chk("rst_tag", dispatch_tag, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endfunction

    function automatic rvfi_wb_t rand_pkt();
        rvfi_wb_t p;
        p.rs1_addr  = rand_reg();
        p.rs2_addr  = rand_reg();
        p.rd_addr   = rand_reg();
        p.rs1_rdata = $urandom();
        p.rs2_rdata = $urandom();
        p.rd_wdata  = $urandom();
        p.pc_wdata  = $urandom();
        p.mem_addr  = $urandom();
        p.mem_rmask = 4'($urandom());
        p.mem_wmask = 4'($urandom());
        p.mem_rdata = $urandom();
        p.mem_wdata = $urandom();
        return p;
    endfunction

    initial begin
        rvfi_wb_t p;
        logic fv;
        logic [TAG_W-1:0] ft;

        // Out-of-order writebacks commit in program order.
        reset_dut();
        for (int i = 0; i < 3; i++) disp(32'h1000 + 32'(4 * i), 32'h13 + 32'(i << 7));
        wb(2, rand_pkt());
        wb(1, rand_pkt());
        wb(0, rand_pkt());
        idle();
        chk("t1_first_commit", rvfi_valid, 1'b1);
        chk("t1_first_order", rvfi_order, 64'd0);
        repeat (3) idle();

        // Full queue, then tag wrap.
        reset_dut();
        for (int i = 0; i < DEPTH; i++) disp(32'h2000 + 32'(4 * i), 32'h33);
        idle();
        chk("t2_full_not_ready", dispatch_ready, 1'b0);
        wb(0, rand_pkt());
        idle();
        chk("t2_commit", rvfi_valid, 1'b1);
        chk("t2_ready_after", dispatch_ready, 1'b1);
        chk("t2_wrap_tag", dispatch_tag, 0);
        disp(32'h3000, 32'h13);
        idle();

        // Flush beats a same-cycle dispatch and a writeback to a squashed tag.
        reset_dut();
        for (int i = 0; i < 5; i++) disp(32'h4000 + 32'(4 * i), 32'h13);
        step(1'b1, 32'h4100, 32'h13, 1'b1, 3, rand_pkt(), 1'b1, 1);
        idle();
        chk("t3_flush_tail", dispatch_tag, 2);
        wb(3, rand_pkt());
        wb(0, rand_pkt());
        wb(1, rand_pkt());
        disp(32'h4200, 32'h93);
        wb(2, rand_pkt());
        repeat (3) idle();

        // x0 normalisation.
        reset_dut();
        disp(32'h5000, 32'h13);
        p = rand_pkt();
        p.rd_addr = 5'd0;  p.rd_wdata  = 32'hDEADBEEF;
        p.rs1_addr = 5'd0; p.rs1_rdata = 32'h1234;
        p.rs2_addr = 5'd7; p.rs2_rdata = 32'h77;
        p.pc_wdata = 32'h5004;
        wb(0, p);
        idle();
        chk("t4_rd_wdata_zero", rvfi_rd_wdata, 32'd0);
        chk("t4_rs1_rdata_zero", rvfi_rs1_rdata, 32'd0);
        chk("t4_rs2_rdata_kept", rvfi_rs2_rdata, 32'h77);

        // Same-cycle dispatch and writeback to the head commits on the next edge.
        reset_dut();
        step(1'b1, 32'h6000, 32'h13, 1'b1, 0, rand_pkt(), 1'b0, '0);
        idle();
        chk("t7_fwd_commit", rvfi_valid, 1'b1);

        // Asynchronous reset with entries pending.
        reset_dut();
        for (int i = 0; i < 5; i++) disp(32'h7000 + 32'(4 * i), 32'h13);
        wb(0, rand_pkt());
        idle();
        async_reset_check();
        step(1'b1, 32'h7100, 32'h13, 1'b1, 0, rand_pkt(), 1'b0, '0);
        idle();
        chk("t6_order_restart", rvfi_order, 64'd0);
        chk("t6_commit", rvfi_valid, 1'b1);

        // Random traffic.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            fv = 1'b0;
            ft = '0;
            if (mq.size() > 0 && $urandom_range(0, 19) == 0) begin
                fv = 1'b1;
                ft = TAG_W'((m_head + $urandom_range(0, mq.size() - 1)) % DEPTH);
            end
            step($urandom_range(0, 9) < 7, $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                 TAG_W'($urandom_range(0, DEPTH - 1)), rand_pkt(), fv, ft);
        end
        repeat (2) idle();

        // Halt instruction: sticky halt and no further commits when detection is built.
        reset_dut();
        disp(32'h8000, 32'h0000_006f);
        disp(32'h8004, 32'h13);
        p = rand_pkt();
        p.pc_wdata = 32'h9000;
        wb(0, p);
        p.pc_wdata = 32'h8008;
        wb(1, p);
        repeat (3) idle();
        disp(32'h8008, 32'h13);
        idle();
`ifdef RVFI_HALT_DETECT_EN
        chk("t5_halt_set", rvfi_halt, 1'b1);
        chk("t5_last_order", rvfi_order, 64'd0);
`else
        chk("t5_halt_tied", rvfi_halt, 1'b0);
        chk("t5_last_order", rvfi_order, 64'd1);
`endif
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
